// File: rtl/md_unit_if.sv
// E-stage to multiply/divide sequencer handshake: issue request in,
// occupancy/stall/commit status and the architectural HI/LO values out.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, d_uses_md,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, d_uses_md,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: computes the result at issue, holds it pending for
// the modelled latency, then commits it to HI/LO and pulses done.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   hi_q, hi_nxt, lo_q, lo_nxt;
    logic [31:0]   pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
    logic          pend_ok, pend_ok_nxt;
    logic          done_q, done_nxt;

    logic          sgn;
    logic          rs_neg, rt_neg;
    logic [63:0]   prod;
    logic [31:0]   abs_rs, abs_rt, uq, ur, quot, rem;

    // Signed ops differ from unsigned only in operand sign handling (md_op[0]==0).
    assign sgn    = ~md.md_op[0];
    assign rs_neg = sgn & md.rs_val[31];
    assign rt_neg = sgn & md.rt_val[31];

    // Low 64 bits of the extended product equal the exact signed/unsigned product.
    assign prod = {{32{rs_neg}}, md.rs_val} * {{32{rt_neg}}, md.rt_val};

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000 rem 0.
    assign abs_rs = rs_neg ? (32'd0 - md.rs_val) : md.rs_val;
    assign abs_rt = rt_neg ? (32'd0 - md.rt_val) : md.rt_val;
    assign uq     = (abs_rt == 32'd0) ? 32'd0 : abs_rs / abs_rt;
    assign ur     = (abs_rt == 32'd0) ? 32'd0 : abs_rs % abs_rt;
    assign quot   = (rs_neg ^ rt_neg) ? (32'd0 - uq) : uq;
    assign rem    = rs_neg ? (32'd0 - ur) : ur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_ok <= pend_ok_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_ok_nxt = pend_ok;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        3'b000, 3'b001: begin
                            pend_hi_nxt = prod[63:32];
                            pend_lo_nxt = prod[31:0];
                            pend_ok_nxt = 1'b1;
                            cnt_nxt     = CW'(MULT_CYCLES);
                            state_nxt   = BUSY;
                        end
                        3'b010, 3'b011: begin
                            pend_hi_nxt = rem;
                            pend_lo_nxt = quot;
                            // Divide by zero still costs full latency but commits nothing.
                            pend_ok_nxt = (md.rt_val != 32'd0);
                            cnt_nxt     = CW'(DIV_CYCLES);
                            state_nxt   = BUSY;
                        end
                        3'b100:  hi_nxt = md.rs_val;
                        3'b101:  lo_nxt = md.rs_val;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    if (pend_ok) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy covers the issue cycle too, so a dependent D-stage op stalls immediately.
    assign md.busy  = (state == BUSY) | (md.start & ~md.md_op[2]);
    assign md.stall = md.d_uses_md & md.busy;
    assign md.done  = done_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed and random stimulus for md_unit_ctrl against a cycle-count reference model.
module tb_md_unit_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if md();
    md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(md));

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO, cycles left until commit, pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_ok, m_done;
    int          m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_ok = 0; m_done = 0; m_left = 0;
    endtask

    task automatic model_issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint a, b, q, r;
        logic [63:0] v;
        if (op[0] == 1'b0) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
        end else begin
            a = longint'({32'd0, rs});
            b = longint'({32'd0, rt});
        end
        if (op[1] == 1'b0) begin
            v = a * b;
            p_hi = v[63:32]; p_lo = v[31:0]; p_ok = 1;
            m_left = MC;
        end else begin
            p_ok = (rt != 0);
            if (p_ok) begin
                q = a / b;
                r = a % b;
                v = q; p_lo = v[31:0];
                v = r; p_hi = v[31:0];
            end
            m_left = DC;
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance the model over the edge.
    task automatic cycle(input bit st, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input bit du);
        bit exp_busy;
        md.start = st; md.md_op = op; md.rs_val = rs; md.rt_val = rt; md.d_uses_md = du;
        @(negedge clk);
        exp_busy = (m_left > 0) || (st && op < 3'd4);
        chk("busy",  md.busy,  exp_busy);
        chk("stall", md.stall, exp_busy & du);
        chk("done",  md.done,  m_done);
        chk("hi",    md.hi,    m_hi);
        chk("lo",    md.lo,    m_lo);
        if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0 && p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else begin
            m_done = 0;
            if (st) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: model_issue(op, rs, rt);
                    3'd4: m_hi = rs;
                    3'd5: m_lo = rs;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit du);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 32'd0, 32'd0, du);
    endtask

    initial begin
        logic [31:0] rs, rt;
        reset = 1'b1;
        md.start = 0; md.md_op = '0; md.rs_val = '0; md.rt_val = '0; md.d_uses_md = 0;
        model_reset();
        #12;
        chk("rst_busy", md.busy, 1'b0);
        chk("rst_done", md.done, 1'b0);
        chk("rst_hi",   md.hi,   32'd0);
        chk("rst_lo",   md.lo,   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // mult -3 * 5
        cycle(1, 3'd0, 32'hFFFFFFFD, 32'd5, 0);
        idle(MC, 0);
        chk("t1_hi", md.hi, 32'hFFFFFFFF);
        chk("t1_lo", md.lo, 32'hFFFFFFF1);
        chk("t1_done", md.done, 1'b1);
        idle(1, 0);

        // multu same operands; old values still visible one edge before commit
        cycle(1, 3'd1, 32'hFFFFFFFD, 32'd5, 0);
        idle(MC - 1, 0);
        chk("t2_old_hi", md.hi, 32'hFFFFFFFF);
        idle(1, 0);
        chk("t2_hi", md.hi, 32'h00000004);
        chk("t2_lo", md.lo, 32'hFFFFFFF1);

        // div 7 / -2, then divu by zero leaves HI/LO alone
        cycle(1, 3'd2, 32'd7, 32'hFFFFFFFE, 0);
        idle(DC, 0);
        chk("t3_hi", md.hi, 32'h00000001);
        chk("t3_lo", md.lo, 32'hFFFFFFFD);
        cycle(1, 3'd3, 32'd7, 32'd0, 0);
        idle(DC, 0);
        chk("t3z_hi", md.hi, 32'h00000001);
        chk("t3z_lo", md.lo, 32'hFFFFFFFD);

        // mflo in D stalls through the busy window; addu in D does not
        cycle(1, 3'd0, 32'd3, 32'd4, 1);
        idle(MC, 1);
        chk("t4_stall_after", md.stall, 1'b0);
        cycle(1, 3'd1, 32'd9, 32'd9, 0);
        idle(MC, 0);

        // reset three cycles into a div
        cycle(1, 3'd2, 32'd100, 32'd7, 0);
        idle(3, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_busy", md.busy, 1'b0);
        chk("t6_hi",   md.hi,   32'd0);
        chk("t6_lo",   md.lo,   32'd0);
        chk("t6_done", md.done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(DC + 2, 0);

        // mtlo with no op in flight
        cycle(1, 3'd5, 32'h12345678, 32'd0, 1);
        chk("t5_lo", md.lo, 32'h12345678);
        chk("t5_busy", md.busy, 1'b0);
        idle(1, 0);

        // random traffic, including starts while busy, 11x ops, zero divisors
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0: rs = 32'h80000000;
                1: rs = 32'hFFFFFFFF;
                default: rs = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rt = 32'd0;
                1: rt = 32'hFFFFFFFF;
                2: rt = $urandom_range(1, 9);
                default: rt = $urandom;
            endcase
            cycle($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), rs, rt,
                  $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
